// File: rtl/controller_poller.sv
// -----------------------------------------------------------------------------
// controller_poller
//   Memory-mapped interface for NUM_CONTROLLERS NES-style serial game pads.
//   All pads share one latch/clock pair and are shifted in parallel. A poll
//   starts on a rising edge of vblank_irq or on a CPU write of 1 to STATUS.
//   Button states are gathered into shadow registers and copied to the
//   CPU-visible registers in a single COMMIT cycle, so a CPU read never sees
//   a half-updated sample.
//
//   Register map (offset = cpu_address):
//     2c     pad c buttons[7:0]   (1 = pressed, button 0 = first bit shifted)
//     2c+1   pad c buttons[15:8]  (bits >= BUTTONS read 0)
//     2N     STATUS = {6'b0, new_data, busy}; write data[0]=1 starts a poll,
//            a read clears new_data
//     other  read 0
//
// Ports
//   clk_12_5875   system clock
//   rst           synchronous active-high reset
//   vblank_irq    poll request on its 0->1 transition
//   select        chip select from the address decoder
//   write_enable  CPU write strobe (qualified by select)
//   cpu_address   register offset
//   data_in       CPU write data
//   data_out      CPU read data (combinational, 0 when not selected)
//   ctrl_latch    shared pad latch, active high
//   ctrl_clk      shared pad shift clock, idles low
//   ctrl_data     per-pad serial data, active low
//   busy          poll in progress
// -----------------------------------------------------------------------------
module controller_poller #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int BUTTONS         = 8,
    parameter int CLK_DIV         = 4,
    parameter int ADDR_W          = 3
) (
    input  logic                       clk_12_5875,
    input  logic                       rst,
    input  logic                       vblank_irq,
    input  logic                       select,
    input  logic                       write_enable,
    input  logic [ADDR_W-1:0]          cpu_address,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    output logic                       ctrl_latch,
    output logic                       ctrl_clk,
    input  logic [NUM_CONTROLLERS-1:0] ctrl_data,
    output logic                       busy
);

    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;

    localparam logic [PH_W-1:0]   PH_CAP      = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_HIGH     = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(BUTTONS - 1);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(2 * NUM_CONTROLLERS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic               new_data_q, new_data_d;
    logic               vblank_prev_q;
    logic               vblank_armed_q;
    logic [NUM_CONTROLLERS-1:0] sync1_q, sync2_q;

    logic status_sel;
    logic cpu_req;
    logic status_rd;
    logic vblank_rise;
    logic trigger;
    logic capture;
    logic commit;

    // Only bit 0 of a STATUS write carries meaning.
    logic unused_data_bits;
    assign unused_data_bits = ^data_in[7:1];

    assign status_sel = select && (cpu_address == STATUS_ADDR);
    assign cpu_req    = status_sel && write_enable && data_in[0];
    assign status_rd  = status_sel && !write_enable;

    // vblank_armed_q stays low until vblank_irq has been seen low after
    // reset, so a level held high across reset release is not mistaken for
    // a fresh edge.
    assign vblank_rise = vblank_irq && !vblank_prev_q && vblank_armed_q;
    assign trigger     = cpu_req || vblank_rise;

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            bit_q          <= '0;
            new_data_q     <= 1'b0;
            vblank_prev_q  <= 1'b0;
            vblank_armed_q <= 1'b0;
            sync1_q        <= '0;
            sync2_q        <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            bit_q          <= bit_d;
            new_data_q     <= new_data_d;
            vblank_prev_q  <= vblank_irq;
            vblank_armed_q <= vblank_armed_q || !vblank_irq;
            sync1_q        <= ctrl_data;
            sync2_q        <= sync1_q;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic. Triggers outside IDLE are simply ignored.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        capture = 1'b0;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_LATCH;
                    phase_d = '0;
                    bit_d   = '0;
                end
            end
            S_LATCH: begin
                if (phase_q == PH_LAST) begin
                    state_d = S_SHIFT;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // Sample on the last low phase, just before the rising edge
                // that makes the pad present its next bit.
                capture = (phase_q == PH_CAP);
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_COMMIT;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A COMMIT coinciding with a STATUS read leaves new_data set, so the
    // fresh sample is never silently acknowledged.
    always_comb begin
        new_data_d = new_data_q;
        if (commit) begin
            new_data_d = 1'b1;
        end else if (status_rd) begin
            new_data_d = 1'b0;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign ctrl_latch = (state_q == S_LATCH);
    assign ctrl_clk   = (state_q == S_SHIFT) && (phase_q >= PH_HIGH);

    // ---------------------------------------------------------------------
    // Per-pad shadow (filled during SHIFT) and visible (updated at COMMIT)
    // ---------------------------------------------------------------------
    logic [NUM_CONTROLLERS-1:0][15:0] pad_words;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_pad
            logic [BUTTONS-1:0] shadow_q;
            logic [BUTTONS-1:0] visible_q;

            always_ff @(posedge clk_12_5875) begin
                if (rst) begin
                    shadow_q  <= '0;
                    visible_q <= '0;
                end else begin
                    if (capture) begin
                        shadow_q[bit_q] <= ~sync2_q[gi];
                    end
                    if (commit) begin
                        visible_q <= shadow_q;
                    end
                end
            end

            assign pad_words[gi] = 16'(visible_q);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // CPU read mux
    // ---------------------------------------------------------------------
    always_comb begin
        data_out = 8'h00;
        if (select) begin
            if (cpu_address == STATUS_ADDR) begin
                data_out = {6'b0, new_data_q, busy};
            end
            for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                if (cpu_address == ADDR_W'(2 * c)) begin
                    data_out = pad_words[c][7:0];
                end
                if (cpu_address == ADDR_W'(2 * c + 1)) begin
                    data_out = pad_words[c][15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_controller_poller.sv
// -----------------------------------------------------------------------------
// tb_controller_poller
//   Directed + randomized bench for controller_poller. Two instances share a
//   clock and reset: the default 2-pad/8-button build and a 12-button build.
//   Each pad is modelled as an NES shift register that restarts on latch and
//   advances on ctrl_clk rising edges. The expected register contents are the
//   pressed masks truncated to BUTTONS bits; expected timing comes from the
//   latch/shift/commit cycle counts.
// -----------------------------------------------------------------------------
module tb_controller_poller;

    localparam int CD       = 4;
    localparam int B        = 8;
    localparam int B12      = 12;
    localparam int EXP_BUSY = 2 * CD + B * 2 * CD + 1;
    localparam int EXP_B12  = 2 * CD + B12 * 2 * CD + 1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       vblank_irq;
    logic       select;
    logic       write_enable;
    logic [2:0] cpu_address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic [1:0] ctrl_data;
    logic       busy;

    logic       vb12;
    logic       sel12;
    logic       we12;
    logic [2:0] addr12;
    logic [7:0] din12;
    logic [7:0] dout12;
    logic       latch12;
    logic       sclk12;
    logic [1:0] data12;
    logic       busy12;

    controller_poller #(
        .NUM_CONTROLLERS(2), .BUTTONS(B), .CLK_DIV(CD), .ADDR_W(3)
    ) dut (
        .clk_12_5875(clk), .rst(rst), .vblank_irq(vblank_irq),
        .select(select), .write_enable(write_enable),
        .cpu_address(cpu_address), .data_in(data_in), .data_out(data_out),
        .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk), .ctrl_data(ctrl_data),
        .busy(busy)
    );

    controller_poller #(
        .NUM_CONTROLLERS(2), .BUTTONS(B12), .CLK_DIV(CD), .ADDR_W(3)
    ) dut12 (
        .clk_12_5875(clk), .rst(rst), .vblank_irq(vb12),
        .select(sel12), .write_enable(we12),
        .cpu_address(addr12), .data_in(din12), .data_out(dout12),
        .ctrl_latch(latch12), .ctrl_clk(sclk12), .ctrl_data(data12),
        .busy(busy12)
    );

    // ---------------------------------------------------------------------
    // Pad models: pressed masks, presented active-low, LSB first
    // ---------------------------------------------------------------------
    logic [15:0] pad_mask   [2];
    logic [15:0] pad12_mask [2];
    int          pad_idx   = 0;
    int          pad12_idx = 0;

    always @(posedge ctrl_clk or posedge ctrl_latch) begin
        if (ctrl_latch) pad_idx <= 0;
        else            pad_idx <= pad_idx + 1;
    end

    always @(posedge sclk12 or posedge latch12) begin
        if (latch12) pad12_idx <= 0;
        else         pad12_idx <= pad12_idx + 1;
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ctrl_data[c] = 1'b1;
            data12[c]    = 1'b1;
            if (pad_idx < 16)   ctrl_data[c] = ~pad_mask[c][pad_idx[3:0]];
            if (pad12_idx < 16) data12[c]    = ~pad12_mask[c][pad12_idx[3:0]];
        end
    end

    // ---------------------------------------------------------------------
    // Reference model and checking helpers
    // ---------------------------------------------------------------------
    logic [15:0] vis_model [2];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [7:0] exp_byte(input logic [15:0] m, input int buttons, input bit hi);
        logic [15:0] v;
        v = m & 16'((32'h1 << buttons) - 1);
        return hi ? v[15:8] : v[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        select       = 1'b1;
        write_enable = 1'b0;
        cpu_address  = a;
        #1;
        d = data_out;
        @(negedge clk);
        select = 1'b0;
    endtask

    task automatic rd12(input logic [2:0] a, output logic [7:0] d);
        sel12  = 1'b1;
        addr12 = a;
        #1;
        d = dout12;
        @(negedge clk);
        sel12 = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        select       = 1'b1;
        write_enable = 1'b1;
        cpu_address  = a;
        data_in      = d;
        @(negedge clk);
        select       = 1'b0;
        write_enable = 1'b0;
        data_in      = 8'h00;
    endtask

    // Count busy cycles seen from `cycles` negedges.
    task automatic count_busy(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
    endtask

    // Run one poll from a negedge. Optionally retrigger (CPU + vblank) or
    // assert reset when the busy count reaches the given value. Always reads
    // pad 0 mid-poll and expects the previously committed sample.
    task automatic poll(input bit use_cpu, input int retrig_at, input int rst_at,
                        output int busy_n, output int latch_n, output int pulse_n);
        logic prev_clk;
        bit   done;
        busy_n   = 0;
        latch_n  = 0;
        pulse_n  = 0;
        prev_clk = 1'b0;
        done     = 1'b0;
        if (use_cpu) begin
            select = 1'b1; write_enable = 1'b1; cpu_address = 3'd4; data_in = 8'h01;
        end else begin
            vblank_irq = 1'b1;
        end
        @(negedge clk);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            select = 1'b0; write_enable = 1'b0; data_in = 8'h00;
            vblank_irq = 1'b0; rst = 1'b0;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            busy_n++;
            if (ctrl_latch) latch_n++;
            if (ctrl_clk && !prev_clk) pulse_n++;
            prev_clk = ctrl_clk;
            if (busy_n == retrig_at) begin
                select = 1'b1; write_enable = 1'b1; cpu_address = 3'd4; data_in = 8'h01;
                vblank_irq = 1'b1;
            end
            if (busy_n == 20) begin
                select = 1'b1; write_enable = 1'b0; cpu_address = 3'd0;
                #1;
                chk("mid_poll_rd0", {24'h0, data_out}, {24'h0, vis_model[0][7:0]});
            end
            if (busy_n == rst_at) rst = 1'b1;
            @(negedge clk);
        end
        chk("poll_terminated", {31'h0, done}, 32'd1);
    endtask

    task automatic check_poll(input string tag, input int busy_n, input int latch_n, input int pulse_n);
        chk({tag, "_busy_cycles"}, busy_n, EXP_BUSY);
        chk({tag, "_latch_cycles"}, latch_n, 2 * CD);
        chk({tag, "_clk_pulses"}, pulse_n, B);
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] d;
        for (int a = 0; a < 4; a++) begin
            rd(3'(a), d);
            chk($sformatf("%s_off%0d", tag, a), {24'h0, d},
                {24'h0, exp_byte(vis_model[a / 2], B, (a % 2) == 1)});
        end
        rd(3'(5 + $urandom_range(0, 2)), d);
        chk({tag, "_unmapped"}, {24'h0, d}, 32'h0);
        rd(3'd4, d);
        chk({tag, "_status_new"}, {24'h0, d}, 32'h02);
        rd(3'd4, d);
        chk({tag, "_status_clr"}, {24'h0, d}, 32'h00);
    endtask

    task automatic commit_model();
        for (int c = 0; c < 2; c++) vis_model[c] = pad_mask[c] & 16'((32'h1 << B) - 1);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic [7:0] d;
        int bn, ln, pn, nb;
        bit done12;

        rst = 1'b1; vblank_irq = 1'b0; select = 1'b0; write_enable = 1'b0;
        cpu_address = 3'd0; data_in = 8'h00;
        vb12 = 1'b0; sel12 = 1'b0; we12 = 1'b0; addr12 = 3'd0; din12 = 8'h00;
        pad_mask[0] = 16'h0; pad_mask[1] = 16'h0;
        pad12_mask[0] = 16'h0; pad12_mask[1] = 16'h0;
        vis_model[0] = 16'h0; vis_model[1] = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_latch", {31'h0, ctrl_latch}, 32'd0);
        chk("rst_clk", {31'h0, ctrl_clk}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_busy12", {31'h0, busy12}, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            chk($sformatf("rst_rd%0d", a), {24'h0, d}, 32'h0);
        end

        // Pad0 0xA5, pad1 idle, vblank trigger
        pad_mask[0] = 16'h00A5;
        pad_mask[1] = 16'h0000;
        poll(1'b0, -1, -1, bn, ln, pn);
        check_poll("a5", bn, ln, pn);
        commit_model();
        check_regs("a5");

        // Writes that must not start a poll
        wr(3'd4, 8'hFE);
        wr(3'd0, 8'h01);
        wr(3'd7, 8'h01);
        count_busy(5, nb);
        chk("ignored_writes_busy", nb, 0);

        // Retrigger mid-SHIFT by both CPU and vblank: dropped
        pad_mask[0] = 16'($urandom);
        pad_mask[1] = 16'($urandom);
        poll(1'b0, 30, -1, bn, ln, pn);
        check_poll("retrig", bn, ln, pn);
        count_busy(20, nb);
        chk("retrig_no_second_poll", nb, 0);
        commit_model();
        check_regs("retrig");

        // Randomized polls, random trigger source
        for (int k = 0; k < 6; k++) begin
            pad_mask[0] = 16'($urandom) | 16'h0001;
            pad_mask[1] = 16'($urandom);
            poll(1'($urandom_range(0, 1)), -1, -1, bn, ln, pn);
            check_poll($sformatf("rnd%0d", k), bn, ln, pn);
            commit_model();
            check_regs($sformatf("rnd%0d", k));
        end

        // Reset during bit 3 of SHIFT: everything cleared, nothing committed
        pad_mask[0] = 16'h00FF;
        pad_mask[1] = 16'h00FF;
        poll(1'b0, -1, 2 * CD + 3 * 2 * CD + 3, bn, ln, pn);
        chk("rst_abort_busy_cycles", bn, 2 * CD + 3 * 2 * CD + 3);
        chk("rst_abort_clk", {31'h0, ctrl_clk}, 32'd0);
        chk("rst_abort_latch", {31'h0, ctrl_latch}, 32'd0);
        chk("rst_abort_busy", {31'h0, busy}, 32'd0);
        vis_model[0] = 16'h0;
        vis_model[1] = 16'h0;
        rd(3'd0, d);
        chk("rst_abort_off0", {24'h0, d}, 32'h0);
        count_busy(100, nb);
        chk("rst_abort_no_commit_busy", nb, 0);
        rd(3'd0, d);
        chk("rst_abort_off0_later", {24'h0, d}, 32'h0);
        rd(3'd4, d);
        chk("rst_abort_status", {24'h0, d}, 32'h0);

        // vblank held high through reset release must not trigger
        vblank_irq = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_busy(10, nb);
        chk("vblank_held_no_trigger", nb, 0);
        vblank_irq = 1'b0;
        @(negedge clk);
        pad_mask[0] = 16'($urandom);
        pad_mask[1] = 16'($urandom);
        poll(1'b0, -1, -1, bn, ln, pn);
        check_poll("post_rst", bn, ln, pn);
        commit_model();
        check_regs("post_rst");

        // 12-button build, pad0 0xABC
        pad12_mask[0] = 16'h0ABC;
        pad12_mask[1] = 16'($urandom);
        vb12 = 1'b1;
        @(negedge clk);
        vb12 = 1'b0;
        nb = 0;
        done12 = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!busy12) begin
                done12 = 1'b1;
                break;
            end
            nb++;
            @(negedge clk);
        end
        chk("b12_terminated", {31'h0, done12}, 32'd1);
        chk("b12_busy_cycles", nb, EXP_B12);
        for (int a = 0; a < 4; a++) begin
            rd12(3'(a), d);
            chk($sformatf("b12_off%0d", a), {24'h0, d},
                {24'h0, exp_byte(pad12_mask[a / 2], B12, (a % 2) == 1)});
        end
        rd12(3'd4, d);
        chk("b12_status", {24'h0, d}, 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
